miner_dispatch: RTL and testbench
=================================

Name: miner_dispatch

Overview:
- Parametrised job dispatcher and golden-nonce collector for NUM_CORES miner cores in the hash_clk domain.
- Splits a job's nonce range [nonce_min, nonce_max] into per-core sub-ranges and starts all cores together.
- Collects single-cycle golden-nonce pulses from the cores through a round-robin arbiter into a FIFO, drained by the UART comm block via valid/ready.
- midstate and work_data are fanned out outside this block; it handles only nonce ranges and results.

Parameters:
- NUM_CORES, 4, number of miner cores; power of 2, 1..16.
- NONCE_W, 32, nonce width.
- FIFO_DEPTH, 8, golden-nonce FIFO entries; power of 2, ≥2.

Ports:
- hash_clk  in  1  hashing clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- new_work  in  1  one-cycle pulse; latch nonce_min/nonce_max and (re)start a job.
- nonce_min  in  NONCE_W  job lower bound, inclusive.
- nonce_max  in  NONCE_W  job upper bound, inclusive.
- core_nonce_min  out  NUM_CORES*NONCE_W  per-core lower bound; core i occupies bits [i*NONCE_W +: NONCE_W].
- core_nonce_max  out  NUM_CORES*NONCE_W  per-core upper bound.
- core_en  out  NUM_CORES  core holds a non-empty range for this job.
- core_start  out  NUM_CORES  one-cycle start pulse to enabled cores.
- core_done  in  NUM_CORES  level; core has exhausted its range.
- core_golden_valid  in  NUM_CORES  one-cycle pulse per found nonce.
- core_golden_nonce  in  NUM_CORES*NONCE_W  nonce accompanying the pulse.
- golden_valid  out  1  FIFO head valid.
- golden_nonce  out  NONCE_W  FIFO head.
- golden_ready  in  1  consumer accepts the head when high together with golden_valid.
- busy  out  1  state is not IDLE.
- job_done  out  1  one-cycle pulse at job end.
- overflow  out  1  sticky; a golden nonce was dropped.

Behaviour:
- Reset values: every output 0, FIFO empty, state IDLE.
- States:
  - IDLE: new_work -> SPLIT.
  - SPLIT: lasts NUM_CORES cycles, index k = 0..N-1; after k = N-1 -> RUN. core_start = core_en for one cycle on the first RUN cycle.
  - RUN: when every core with core_en=1 has core_done=1 -> DONE.
  - DONE: one cycle, job_done=1, then IDLE.
- Split arithmetic:
  - span = {1'b0,nonce_max} - nonce_min + 1, 33 bits; chunk = span >> log2(NUM_CORES).
  - Core k: lo = nonce_min + k*chunk, formed by an accumulator, not a multiplier; hi = lo + chunk - 1.
  - Last core: hi = nonce_max, so it absorbs the remainder.
- chunk == 0 (span < NUM_CORES): core k enabled iff k < span, with lo = hi = nonce_min + k. Other cores: core_en=0, ranges 0.
- nonce_max < nonce_min: empty job. Go SPLIT -> DONE directly, all core_en=0, no core_start.
- Full range 0..2^32-1: span = 2^32, handled exactly in 33 bits.
- new_work while not IDLE: abort the current job and restart SPLIT next cycle. Clear core_en, all pending holding registers and the FIFO. No job_done pulse for the aborted job. core_done from the old job is ignored until the new core_start.
- Collection path:
  - Each core has a 1-entry holding register, loaded on core_golden_valid.
  - Round-robin arbiter moves one occupied holding register per cycle into the FIFO when the FIFO is not full (or is being popped the same cycle). Priority pointer advances past the winner.
  - A pulse arriving while that core's holding register is still occupied is dropped and sets overflow.
  - Pulses are accepted in any state except during the abort-flush cycle.
- FIFO:
  - Push and pop in the same cycle are allowed, including when full.
  - golden_nonce is stable while golden_valid=1 and golden_ready=0.
  - Latency from core pulse to golden_valid, FIFO empty and no contention: 2 cycles.
- overflow clears only on reset_n.

Optional Feature:
- MINER_CORE_TAG_EN defined: adds output golden_core_id, width $clog2(NUM_CORES) (min 1). The FIFO stores the winning core index alongside the nonce, presented with golden_nonce.
- Undefined: port absent, FIFO width NONCE_W.

Decomposition:
- miner_pkg holds:
  - state encoding localparams (IDLE, SPLIT, RUN, DONE);
  - NONCE_W default;
  - a clog2-safe width helper constant for core index.
- One sub-module: miner_golden_fifo, a synchronous FIFO parametrised by width and depth, with a flush input used on abort.

Test Plan:
- NUM_CORES=4, new_work with min=0x0000_0000, max=0x0000_03FF -> ranges [0,FF],[100,1FF],[200,2FF],[300,3FF]; core_start=4'b1111 on cycle 6 after new_work; all core_done -> job_done pulse, busy=0 next cycle.
- min=0x10, max=0x12 -> core_en=4'b0111, ranges [10,10],[11,11],[12,12]; core 3 disabled; job completes without core 3 done.
- min=5, max=4 -> no core_start, job_done pulse exactly 3 cycles after new_work.
- Cores 0 and 2 pulse golden in the same cycle with 0xDEADBEEF and 0xCAFEF00D, golden_ready=1 -> both emerge in round-robin order on consecutive cycles, overflow=0.
- golden_ready=0, core 1 pulses 10 times, FIFO_DEPTH=8 -> 8 entries held in order, 1 in the holding register, 1 dropped, overflow=1.
- new_work mid-RUN with 3 FIFO entries -> golden_valid drops to 0 next cycle, new split ranges issued, no job_done for the old job.

Source files
------------

// File: rtl/miner_pkg.sv
// miner_pkg: shared FSM states, nonce width default and core-index width helper
package miner_pkg;
  typedef enum logic [1:0] {IDLE, SPLIT, RUN, DONE} state_t;
  localparam int NONCE_W_DEF = 32;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/miner_golden_fifo.sv
// miner_golden_fifo: synchronous golden-nonce FIFO with flush, push+pop allowed when full
module miner_golden_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  assign valid = wr != rd;
  assign full = (wr ^ rd) == {1'b1, {AW{1'b0}}};
  assign dout = valid ? mem[rd[AW-1:0]] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/miner_dispatch.sv
// miner_dispatch: nonce-range splitter and round-robin golden-nonce collector (MINER_CORE_TAG_EN adds golden_core_id)
module miner_dispatch
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         hash_clk,
  input  logic                         reset_n,
  input  logic                         new_work,
  input  logic [NONCE_W-1:0]           nonce_min,
  input  logic [NONCE_W-1:0]           nonce_max,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce_min,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce_max,
  output logic [NUM_CORES-1:0]         core_en,
  output logic [NUM_CORES-1:0]         core_start,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES-1:0]         core_golden_valid,
  input  logic [NUM_CORES*NONCE_W-1:0] core_golden_nonce,
  output logic                         golden_valid,
  output logic [NONCE_W-1:0]           golden_nonce,
`ifdef MINER_CORE_TAG_EN
  output logic [idx_w(NUM_CORES)-1:0]  golden_core_id,
`endif
  input  logic                         golden_ready,
  output logic                         busy,
  output logic                         job_done,
  output logic                         overflow
);
  localparam int IW = idx_w(NUM_CORES);
  localparam int SW = NONCE_W + 1;
  localparam int LOG2N = $clog2(NUM_CORES);
`ifdef MINER_CORE_TAG_EN
  localparam int FW = NONCE_W + IW;
`else
  localparam int FW = NONCE_W;
`endif
  state_t state, state_n;
  logic go, first, flush, empty, last, en_k, found, push, pop, full;
  logic [NONCE_W-1:0] min_r, max_r;
  logic [SW-1:0] span, chunk, step, acc;
  logic [IW-1:0] k, ptr, win;
  logic [NONCE_W-1:0] lo [NUM_CORES];
  logic [NONCE_W-1:0] hi [NUM_CORES];
  logic [NONCE_W-1:0] hold_n [NUM_CORES];
  logic [NUM_CORES-1:0] hold_v, gnt, drop;
  logic [FW-1:0] fifo_dout;
  assign flush = new_work && (state != IDLE || go);
  assign empty = max_r < min_r;
  assign span = {1'b0, max_r} - {1'b0, min_r} + 1'b1;
  assign chunk = span >> LOG2N;
  assign step = chunk == '0 ? SW'(1) : chunk;
  assign last = k == IW'(NUM_CORES - 1);
  assign en_k = chunk != '0 || SW'(k) < span;
  assign busy = state != IDLE;
  assign job_done = state == DONE;
  assign core_start = state == RUN && first ? core_en : '0;
  always_ff @(posedge hash_clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? SPLIT : IDLE;
      SPLIT:   state_n = empty ? DONE : last ? RUN : SPLIT;
      RUN:     state_n = !first && (core_done & core_en) == core_en ? DONE : RUN;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end
  always_ff @(posedge hash_clk or negedge reset_n)
    if (!reset_n) begin
      go <= 1'b0;
      first <= 1'b0;
      min_r <= '0;
      max_r <= '0;
      acc <= '0;
      k <= '0;
      core_en <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        lo[i] <= '0;
        hi[i] <= '0;
      end
    end else begin
      go <= new_work;
      first <= state == SPLIT && state_n == RUN;
      if (new_work) begin
        min_r <= nonce_min;
        max_r <= nonce_max;
      end
      if (flush || go) begin
        core_en <= '0;
        k <= '0;
        acc <= {1'b0, min_r};
        for (int i = 0; i < NUM_CORES; i++) begin
          lo[i] <= '0;
          hi[i] <= '0;
        end
      end else if (state == SPLIT && !empty) begin
        core_en[k] <= en_k;
        lo[k] <= en_k ? acc[NONCE_W-1:0] : '0;
        hi[k] <= !en_k ? '0 : last ? max_r : NONCE_W'(acc + step - 1'b1);
        acc <= acc + step;
        k <= k + 1'b1;
      end
    end
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_pack
    assign core_nonce_min[g*NONCE_W +: NONCE_W] = lo[g];
    assign core_nonce_max[g*NONCE_W +: NONCE_W] = hi[g];
  end
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int j = 0; j < NUM_CORES; j++)
      if (!found && hold_v[(int'(ptr) + j) % NUM_CORES]) begin
        found = 1'b1;
        win = IW'((int'(ptr) + j) % NUM_CORES);
      end
  end
  assign pop = golden_ready && golden_valid;
  assign push = found && (!full || pop) && !flush;
  assign gnt = push ? NUM_CORES'(1) << win : '0;
  assign drop = core_golden_valid & hold_v & ~gnt & {NUM_CORES{!flush}};
  always_ff @(posedge hash_clk or negedge reset_n)
    if (!reset_n) begin
      hold_v <= '0;
      ptr <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) hold_n[i] <= '0;
    end else begin
      overflow <= overflow | (|drop);
      if (push) ptr <= IW'((int'(win) + 1) % NUM_CORES);
      for (int i = 0; i < NUM_CORES; i++)
        if (flush) hold_v[i] <= 1'b0;
        else if (core_golden_valid[i] && (!hold_v[i] || gnt[i])) begin
          hold_v[i] <= 1'b1;
          hold_n[i] <= core_golden_nonce[i*NONCE_W +: NONCE_W];
        end else if (gnt[i]) hold_v[i] <= 1'b0;
    end
  miner_golden_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(hash_clk),
    .rst_n(reset_n),
    .flush(flush),
    .push(push),
`ifdef MINER_CORE_TAG_EN
    .din({win, hold_n[win]}),
`else
    .din(hold_n[win]),
`endif
    .pop(pop),
    .dout(fifo_dout),
    .valid(golden_valid),
    .full(full)
  );
  assign golden_nonce = fifo_dout[NONCE_W-1:0];
`ifdef MINER_CORE_TAG_EN
  assign golden_core_id = fifo_dout[FW-1:NONCE_W];
`endif
endmodule

// File: tb/tb_miner_dispatch.sv
// tb_miner_dispatch: directed self-checking bench for miner_dispatch
module tb_miner_dispatch;
  logic hash_clk, reset_n, new_work, golden_ready, golden_valid, busy, job_done, overflow;
  logic [31:0] nonce_min, nonce_max, golden_nonce;
  logic [127:0] cmin, cmax, gnonce_in;
  logic [3:0] en, start, done, gv;
`ifdef MINER_CORE_TAG_EN
  logic [1:0] core_id;
`endif
  int tests = 0;
  int fails = 0;
  int jd;
  miner_dispatch dut (
    .hash_clk(hash_clk),
    .reset_n(reset_n),
    .new_work(new_work),
    .nonce_min(nonce_min),
    .nonce_max(nonce_max),
    .core_nonce_min(cmin),
    .core_nonce_max(cmax),
    .core_en(en),
    .core_start(start),
    .core_done(done),
    .core_golden_valid(gv),
    .core_golden_nonce(gnonce_in),
    .golden_valid(golden_valid),
    .golden_nonce(golden_nonce),
`ifdef MINER_CORE_TAG_EN
    .golden_core_id(core_id),
`endif
    .golden_ready(golden_ready),
    .busy(busy),
    .job_done(job_done),
    .overflow(overflow)
  );
  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;
  task automatic tick(input int n);
    repeat (n) @(negedge hash_clk);
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [31:0] lo, input logic [31:0] hi);
    nonce_min = lo;
    nonce_max = hi;
    new_work = 1'b1;
    tick(1);
    new_work = 1'b0;
    tick(4);
  endtask
  initial begin
    reset_n = 1'b0;
    new_work = 1'b0;
    nonce_min = '0;
    nonce_max = '0;
    done = '0;
    gv = '0;
    gnonce_in = '0;
    golden_ready = 1'b0;
    tick(3);
    chk("rst_cmin", cmin, '0);
    chk("rst_cmax", cmax, '0);
    chk("rst_en", en, '0);
    chk("rst_start", start, '0);
    chk("rst_gvalid", golden_valid, 0);
    chk("rst_gnonce", golden_nonce, '0);
    chk("rst_busy", busy, 0);
    chk("rst_jobdone", job_done, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    tick(2);
    chk("idle_busy", busy, 0);
    launch(32'h0, 32'h3FF);
    chk("t1_start_c5", start, 4'h0);
    chk("t1_busy", busy, 1);
    tick(1);
    chk("t1_start_c6", start, 4'hF);
    chk("t1_en", en, 4'hF);
    chk("t1_cmin", cmin, 128'h00000300_00000200_00000100_00000000);
    chk("t1_cmax", cmax, 128'h000003FF_000002FF_000001FF_000000FF);
    tick(1);
    chk("t1_start_c7", start, 4'h0);
    done = 4'hF;
    tick(1);
    chk("t1_jobdone", job_done, 1);
    tick(1);
    chk("t1_jobdone_off", job_done, 0);
    chk("t1_busy_off", busy, 0);
    done = 4'h0;
    launch(32'h10, 32'h12);
    tick(1);
    chk("t2_en", en, 4'b0111);
    chk("t2_start", start, 4'b0111);
    chk("t2_cmin", cmin, 128'h00000000_00000012_00000011_00000010);
    chk("t2_cmax", cmax, 128'h00000000_00000012_00000011_00000010);
    tick(1);
    done = 4'b0111;
    tick(1);
    chk("t2_jobdone", job_done, 1);
    tick(1);
    chk("t2_busy_off", busy, 0);
    done = 4'h0;
    launch(32'h0, 32'h9);
    tick(1);
    chk("rem_cmin", cmin, 128'h00000006_00000004_00000002_00000000);
    chk("rem_cmax", cmax, 128'h00000009_00000005_00000003_00000001);
    tick(1);
    done = 4'hF;
    tick(1);
    chk("rem_jobdone", job_done, 1);
    tick(1);
    done = 4'h0;
    launch(32'h0, 32'hFFFF_FFFF);
    tick(1);
    chk("full_en", en, 4'hF);
    chk("full_cmin", cmin, 128'hC0000000_80000000_40000000_00000000);
    chk("full_cmax", cmax, 128'hFFFFFFFF_BFFFFFFF_7FFFFFFF_3FFFFFFF);
    tick(1);
    done = 4'hF;
    tick(1);
    chk("full_jobdone", job_done, 1);
    tick(1);
    done = 4'h0;
    nonce_min = 32'd5;
    nonce_max = 32'd4;
    new_work = 1'b1;
    tick(1);
    new_work = 1'b0;
    tick(1);
    chk("empty_jd_c2", job_done, 0);
    chk("empty_start_c2", start, 4'h0);
    tick(1);
    chk("empty_jd_c3", job_done, 1);
    chk("empty_en", en, 4'h0);
    chk("empty_start_c3", start, 4'h0);
    tick(1);
    chk("empty_jd_c4", job_done, 0);
    chk("empty_busy", busy, 0);
    golden_ready = 1'b1;
    gv = 4'b0101;
    gnonce_in = {32'h0, 32'hCAFEF00D, 32'h0, 32'hDEADBEEF};
    tick(1);
    gv = 4'b0000;
    chk("rr_lat1", golden_valid, 0);
    tick(1);
    chk("rr_v0", golden_valid, 1);
    chk("rr_n0", golden_nonce, 32'hDEADBEEF);
    tick(1);
    chk("rr_v1", golden_valid, 1);
    chk("rr_n1", golden_nonce, 32'hCAFEF00D);
    tick(1);
    chk("rr_empty", golden_valid, 0);
    chk("rr_ovf", overflow, 0);
    golden_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("ovf_before", overflow, 0);
      gv = 4'b0010;
      gnonce_in = {32'h0, 32'h0, 32'(32'h100 + i), 32'h0};
      tick(1);
    end
    gv = 4'b0000;
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", golden_valid, 1);
    golden_ready = 1'b1;
    for (int m = 0; m < 9; m++) begin
      chk($sformatf("ovf_head%0d", m), golden_nonce, 128'(32'h100 + m));
      tick(1);
    end
    chk("ovf_drained", golden_valid, 0);
    chk("ovf_sticky", overflow, 1);
    golden_ready = 1'b0;
    launch(32'h0, 32'h3FF);
    tick(1);
    chk("ab_start_old", start, 4'hF);
    for (int i = 0; i < 3; i++) begin
      gv = 4'b1000;
      gnonce_in = {32'(32'hA0 + i), 96'h0};
      tick(1);
    end
    gv = 4'b0000;
    tick(2);
    chk("ab_fifo_valid", golden_valid, 1);
    chk("ab_fifo_head", golden_nonce, 32'hA0);
    nonce_min = 32'h1000;
    nonce_max = 32'h13FF;
    new_work = 1'b1;
    tick(1);
    new_work = 1'b0;
    jd = 0;
    jd += int'(job_done);
    chk("ab_valid_drop", golden_valid, 0);
    chk("ab_en_clear", en, 4'h0);
    chk("ab_ovf_sticky", overflow, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      jd += int'(job_done);
    end
    chk("ab_no_jobdone", jd, 0);
    chk("ab_start_new", start, 4'hF);
    chk("ab_cmin", cmin, 128'h00001300_00001200_00001100_00001000);
    chk("ab_cmax", cmax, 128'h000013FF_000012FF_000011FF_000010FF);
    tick(1);
    done = 4'hF;
    tick(1);
    chk("ab_jobdone", job_done, 1);
    tick(1);
    chk("ab_busy_off", busy, 0);
    done = 4'h0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
